// File: rtl/upsample_stream_if.sv
// Stream bundle for upsample_stream: pixel input side (data/valid/ready)
// and upsampled output side (data/valid/ready plus end-of-row/frame flags).
// The design takes the slave view; the producer/consumer pair takes master.
interface upsample_stream_if #(
  parameter int C          = 4,
  parameter int DATA_WIDTH = 16
);
  logic [C*DATA_WIDTH-1:0] in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic [C*DATA_WIDTH-1:0] out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_eol;
  logic                    out_eof;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_eol, out_eof
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_eol, out_eof
  );
endinterface

// File: rtl/upsample_stream.sv
// Streaming nearest-neighbour upsampler (YOLOv5 neck). Each input pixel is
// emitted S times horizontally; each row is emitted S times vertically, the
// first pass straight from the input (FILL) and the rest from a one-row line
// buffer (REPLAY). One output beat per cycle when downstream is ready.
// Optional feature: define UPSAMPLE_FRAME_CNT_EN to add a 16-bit frame_cnt
// output counting accepted end-of-frame beats.
module upsample_stream #(
  parameter int C          = 4,
  parameter int DATA_WIDTH = 16,
  parameter int W          = 13,
  parameter int H          = 13,
  parameter int S          = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  upsample_stream_if.slave bus
`ifdef UPSAMPLE_FRAME_CNT_EN
  ,
  output logic [15:0]      frame_cnt
`endif
);
  localparam int PW    = C * DATA_WIDTH;
  localparam int COL_W = (W > 1) ? $clog2(W) : 1;
  localparam int ROW_W = (H > 1) ? $clog2(H) : 1;
  localparam int REP_W = (S > 1) ? $clog2(S) : 1;

  typedef enum logic {FILL, REPLAY} state_t;

  state_t            state_reg, state_next;
  logic [COL_W-1:0]  col_reg, col_next;
  logic [ROW_W-1:0]  row_reg, row_next;
  logic [REP_W-1:0]  hrep_reg, hrep_next;
  logic [REP_W-1:0]  vrep_reg, vrep_next;
  logic [PW-1:0]     out_data_reg, out_data_next;
  logic              out_valid_reg, out_valid_next;
  logic              out_eol_reg, out_eol_next;
  logic              out_eof_reg, out_eof_next;

  logic [PW-1:0]     line_buf [W];

  logic adv, in_ready_int, accept, emit, buf_we;
  logic first_copy, last_copy, col_last, row_last, vrep_last, eol_beat, eof_beat;

  // hrep counts remaining copies of the current pixel; 0 means a fresh pixel
  assign first_copy = (hrep_reg == '0);
  assign last_copy  = first_copy ? (S == 1) : (hrep_reg == REP_W'(1));
  assign col_last   = (col_reg == COL_W'(W - 1));
  assign row_last   = (row_reg == ROW_W'(H - 1));
  assign vrep_last  = (vrep_reg == REP_W'(S - 1));
  assign eol_beat   = col_last && last_copy;
  assign eof_beat   = eol_beat && row_last && vrep_last;

  assign adv          = !out_valid_reg || bus.out_ready;
  assign in_ready_int = (state_reg == FILL) && adv && first_copy;
  assign bus.in_ready = in_ready_int && rst_n;
  assign accept       = bus.in_valid && in_ready_int;

  assign bus.out_data  = out_data_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_eol   = out_eol_reg;
  assign bus.out_eof   = out_eof_reg;

  // Next beat selection and raster position bookkeeping
  always_comb begin
    state_next     = state_reg;
    col_next       = col_reg;
    row_next       = row_reg;
    hrep_next      = hrep_reg;
    vrep_next      = vrep_reg;
    out_data_next  = out_data_reg;
    out_valid_next = out_valid_reg;
    out_eol_next   = out_eol_reg;
    out_eof_next   = out_eof_reg;
    emit           = 1'b0;
    buf_we         = 1'b0;

    if (adv) begin
      if (state_reg == REPLAY) begin
        emit          = 1'b1;
        out_data_next = line_buf[col_reg];
      end else if (!first_copy) begin
        emit = 1'b1;
      end else if (accept) begin
        emit          = 1'b1;
        buf_we        = 1'b1;
        out_data_next = bus.in_data;
      end
      out_valid_next = emit;
      out_eol_next   = emit && eol_beat;
      out_eof_next   = emit && eof_beat;
    end

    if (emit) begin
      hrep_next = first_copy ? REP_W'(S - 1) : hrep_reg - REP_W'(1);
      if (last_copy) begin
        if (!col_last) begin
          col_next = col_reg + COL_W'(1);
        end else begin
          col_next = '0;
          if (vrep_last) begin
            // last vertical copy done: take the next input row
            vrep_next  = '0;
            state_next = FILL;
            row_next   = row_last ? '0 : row_reg + ROW_W'(1);
          end else begin
            vrep_next  = vrep_reg + REP_W'(1);
            state_next = REPLAY;
          end
        end
      end
    end
  end

  // State, counters and output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= FILL;
      col_reg       <= '0;
      row_reg       <= '0;
      hrep_reg      <= '0;
      vrep_reg      <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_eol_reg   <= 1'b0;
      out_eof_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      col_reg       <= col_next;
      row_reg       <= row_next;
      hrep_reg      <= hrep_next;
      vrep_reg      <= vrep_next;
      out_data_reg  <= out_data_next;
      out_valid_reg <= out_valid_next;
      out_eol_reg   <= out_eol_next;
      out_eof_reg   <= out_eof_next;
    end
  end

  // Line buffer captures each FILL row for the REPLAY passes
  always_ff @(posedge clk) begin
    if (buf_we) begin
      line_buf[col_reg] <= bus.in_data;
    end
  end

`ifdef UPSAMPLE_FRAME_CNT_EN
  // Count frames whose final beat was taken downstream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (out_valid_reg && bus.out_ready && out_eof_reg) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_upsample_stream.sv
// Bench for upsample_stream: S=2 instance plus an S=1 instance, small 4x2
// frames, scoreboard of expected beats built from the nearest-neighbour rule.
module tb_upsample_stream;
  localparam int TC  = 2;
  localparam int TDW = 16;
  localparam int TW  = 4;
  localparam int TH  = 2;
  localparam int TS  = 2;
  localparam int PW  = TC * TDW;

  typedef struct packed {
    logic [PW-1:0] data;
    logic          eol;
    logic          eof;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  upsample_stream_if #(.C(TC), .DATA_WIDTH(TDW)) bus ();
  upsample_stream_if #(.C(TC), .DATA_WIDTH(TDW)) bus1 ();

`ifdef UPSAMPLE_FRAME_CNT_EN
  logic [15:0] frame_cnt;
  logic [15:0] frame_cnt1;
`endif

  upsample_stream #(.C(TC), .DATA_WIDTH(TDW), .W(TW), .H(TH), .S(TS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef UPSAMPLE_FRAME_CNT_EN
    ,
    .frame_cnt (frame_cnt)
`endif
  );

  upsample_stream #(.C(TC), .DATA_WIDTH(TDW), .W(TW), .H(TH), .S(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
`ifdef UPSAMPLE_FRAME_CNT_EN
    ,
    .frame_cnt (frame_cnt1)
`endif
  );

  beat_t         exp_q[$];
  logic [PW-1:0] pix_q[$];
  bit            rdy_log[$];
  int total = 0;
  int bad = 0;
  int beats_seen;
  int cycles_used;

  function automatic logic [PW-1:0] pix(input int n);
    return {TDW'(n), TDW'(n)};
  endfunction

  // in_ready is high exactly when the next beat to load is the first copy
  // of a pixel in the first vertical pass of a row
  function automatic bit in_ready_model(input int k);
    int h;
    int v;
    h = k % TS;
    v = (k / (TS * TW)) % TS;
    return (h == 0) && (v == 0);
  endfunction

  task automatic queue_frame(input int base, input int s);
    beat_t b;
    for (int r = 0; r < TH; r++)
      for (int c = 0; c < TW; c++)
        pix_q.push_back(pix(base + r * TW + c));
    for (int r = 0; r < TH; r++)
      for (int v = 0; v < s; v++)
        for (int c = 0; c < TW; c++)
          for (int h = 0; h < s; h++) begin
            b.data = pix(base + r * TW + c);
            b.eol  = (c == TW - 1) && (h == s - 1);
            b.eof  = b.eol && (r == TH - 1) && (v == s - 1);
            exp_q.push_back(b);
          end
  endtask

  task automatic run(input bit sel, input int rdy_pct, input int stop_beats, input int budget);
    logic ov, eol, eof, ir, ordy, iv;
    logic [PW-1:0] od, prev_od;
    bit prev_stall;
    beat_t e;
    beats_seen = 0;
    cycles_used = 0;
    prev_stall = 1'b0;
    prev_od = '0;
    rdy_log.delete();
    while (exp_q.size() > 0 && beats_seen < stop_beats && cycles_used < budget) begin
      @(negedge clk);
      ordy = ($urandom_range(0, 99) < rdy_pct);
      iv = (pix_q.size() > 0);
      if (sel) begin
        bus1.in_valid = iv;
        bus1.in_data = iv ? pix_q[0] : '0;
        bus1.out_ready = ordy;
      end else begin
        bus.in_valid = iv;
        bus.in_data = iv ? pix_q[0] : '0;
        bus.out_ready = ordy;
      end
      #1;
      if (sel) begin
        ov = bus1.out_valid; od = bus1.out_data; eol = bus1.out_eol;
        eof = bus1.out_eof; ir = bus1.in_ready;
      end else begin
        ov = bus.out_valid; od = bus.out_data; eol = bus.out_eol;
        eof = bus.out_eof; ir = bus.in_ready;
      end
      if (prev_stall) begin
        total++;
        if (od !== prev_od) begin
          bad++;
          $display("FAIL stable_during_stall: out_data=%h, held value=%h", od, prev_od);
        end
      end
      rdy_log.push_back(ir === 1'b1);
      if (iv && ir === 1'b1) void'(pix_q.pop_front());
      if (ov === 1'b1 && ordy) begin
        e = exp_q.pop_front();
        total++;
        if ({od, eol, eof} !== {e.data, e.eol, e.eof}) begin
          bad++;
          $display("FAIL beat%0d: got data=%h eol=%b eof=%b, want data=%h eol=%b eof=%b",
                   beats_seen + 1, od, eol, eof, e.data, e.eol, e.eof);
        end
        beats_seen++;
      end
      prev_stall = (ov === 1'b1) && !ordy;
      prev_od = od;
      cycles_used++;
    end
    total++;
    if (exp_q.size() > 0 && beats_seen < stop_beats) begin
      bad++;
      $display("FAIL timeout: %0d beats still expected after %0d cycles", exp_q.size(), cycles_used);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus1.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus1.out_ready = 1'b1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.out_eol !== 1'b0 || bus.out_eof !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags: valid=%b eol=%b eof=%b, want 0 0 0",
               bus.out_valid, bus.out_eol, bus.out_eof);
    end
    total++;
    if (bus.out_data !== '0) begin
      bad++;
      $display("FAIL reset_data: got %h, want 0", bus.out_data);
    end
    total++;
    if (bus.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_in_ready: got %b, want 0", bus.in_ready);
    end
`ifdef UPSAMPLE_FRAME_CNT_EN
    total++;
    if (frame_cnt !== 16'd0) begin
      bad++;
      $display("FAIL reset_frame_cnt: got %0d, want 0", frame_cnt);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL in_ready_after_release: got %b, want 1", bus.in_ready);
    end
    $display("reset: checks done");
  endtask

  task automatic test_basic();
    queue_frame(1, TS);
    run(1'b0, 100, 1000, 200);
    total++;
    if (cycles_used != 33 || beats_seen != 32) begin
      bad++;
      $display("FAIL basic_throughput: %0d beats in %0d cycles, want 32 in 33", beats_seen, cycles_used);
    end
    $display("basic: %0d beats in %0d cycles", beats_seen, cycles_used);
  endtask

  task automatic test_random_ready();
    queue_frame(1, TS);
    run(1'b0, 50, 1000, 2000);
    $display("random_ready: %0d beats in %0d cycles", beats_seen, cycles_used);
  endtask

  task automatic test_in_ready();
    int zeros [TH];
    queue_frame(1, TS);
    run(1'b0, 100, 1000, 200);
    for (int r = 0; r < TH; r++) zeros[r] = 0;
    for (int k = 0; k < rdy_log.size(); k++) begin
      total++;
      if (rdy_log[k] != in_ready_model(k)) begin
        bad++;
        $display("FAIL in_ready_cycle%0d: got %b, want %b", k, rdy_log[k], in_ready_model(k));
      end
      if (k < TH * TS * TS * TW && ((k / (TS * TW)) % TS) != 0 && !rdy_log[k])
        zeros[k / (TS * TS * TW)]++;
    end
    for (int r = 0; r < TH; r++) begin
      total++;
      if (zeros[r] != 8) begin
        bad++;
        $display("FAIL replay_stall_row%0d: in_ready low %0d cycles, want 8", r, zeros[r]);
      end
    end
    $display("in_ready: %0d cycles logged", rdy_log.size());
  endtask

  task automatic test_scale1();
    queue_frame(1, 1);
    run(1'b1, 100, 1000, 100);
    total++;
    if (beats_seen != 8 || cycles_used != 9) begin
      bad++;
      $display("FAIL scale1_count: %0d beats in %0d cycles, want 8 in 9", beats_seen, cycles_used);
    end
    $display("scale1: %0d beats", beats_seen);
  endtask

  task automatic test_reset_midframe();
    queue_frame(1, TS);
    run(1'b0, 100, 5, 200);
    total++;
    if (beats_seen != 5) begin
      bad++;
      $display("FAIL midframe_prefix: got %0d beats, want 5", beats_seen);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL midframe_async_reset: valid=%b in_ready=%b, want 0 0", bus.out_valid, bus.in_ready);
    end
    exp_q.delete();
    pix_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    queue_frame('h11, TS);
    run(1'b0, 100, 1000, 200);
    total++;
    if (cycles_used != 33) begin
      bad++;
      $display("FAIL midframe_restart: took %0d cycles, want 33", cycles_used);
    end
    $display("reset_midframe: restart frame %0d beats", beats_seen);
  endtask

  task automatic test_back_to_back();
    pulse_reset();
    queue_frame('h01, TS);
    queue_frame('h21, TS);
    queue_frame('h41, TS);
    run(1'b0, 100, 1000, 500);
    total++;
    if (beats_seen != 96 || cycles_used != 97) begin
      bad++;
      $display("FAIL back_to_back: %0d beats in %0d cycles, want 96 in 97", beats_seen, cycles_used);
    end
`ifdef UPSAMPLE_FRAME_CNT_EN
    #1;
    total++;
    if (frame_cnt !== 16'd3) begin
      bad++;
      $display("FAIL frame_cnt: got %0d, want 3", frame_cnt);
    end
`endif
    $display("back_to_back: %0d beats in %0d cycles", beats_seen, cycles_used);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b1;
    bus1.in_valid = 1'b0;
    bus1.in_data = '0;
    bus1.out_ready = 1'b1;
    test_reset();
    test_basic();
    test_random_ready();
    test_in_ready();
    test_scale1();
    test_reset_midframe();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
